// File: rtl/bloom_rule_loader_if.sv
// Rule/clear request and bit-array write port bundle for bloom_rule_loader.
// insert_count exists only when LOADER_STATS_EN is defined.
interface bloom_rule_loader_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  rule_valid;
  logic                  rule_ready;
  logic [71:0]           ip_protocol;
  logic [15:0]           src_port;
  logic [15:0]           dst_port;
  logic                  clear_req;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_data;
  logic                  done;
`ifdef LOADER_STATS_EN
  logic [15:0]           insert_count;

  modport master (
    output rule_valid, ip_protocol, src_port, dst_port, clear_req,
    input  rule_ready, wr_en, wr_addr, wr_data, done, insert_count
  );
  modport slave (
    input  rule_valid, ip_protocol, src_port, dst_port, clear_req,
    output rule_ready, wr_en, wr_addr, wr_data, done, insert_count
  );
`else
  modport master (
    output rule_valid, ip_protocol, src_port, dst_port, clear_req,
    input  rule_ready, wr_en, wr_addr, wr_data, done
  );
  modport slave (
    input  rule_valid, ip_protocol, src_port, dst_port, clear_req,
    output rule_ready, wr_en, wr_addr, wr_data, done
  );
`endif
endinterface

// File: rtl/bloom_rule_loader.sv
// Bloom filter write side: hashes a rule into 3 bit indices and sets them, or clears the array.
// Optional feature macro: LOADER_STATS_EN adds the saturating insert_count output.
module bloom_rule_loader #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bloom_rule_loader_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_MIX1, S_MIX2, S_WR0, S_WR1, S_WR2, S_CLR, S_DONE
  } state_t;

  state_t                state, state_n;
  logic [31:0]           a, b, c;
  logic [31:0]           mix_ba, h1, h2, h3;
  logic [ADDR_WIDTH-1:0] idx2, idx3;

  logic                  rule_ready_q, wr_en_q, wr_data_q, done_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  wr_en_n, wr_data_n;
  logic [ADDR_WIDTH-1:0] wr_addr_n;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // The three indices share one mixed 'a'; only the shift amount differs.
  assign mix_ba = b ^ a;
  assign h1     = mix_ba - rotl(a, 14);
  assign h2     = mix_ba - rotl(a, 22);
  assign h3     = mix_ba - rotl(a, 16);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_n   = state;
    wr_en_n   = 1'b0;
    wr_data_n = 1'b0;
    wr_addr_n = '0;
    unique case (state)
      S_IDLE: begin
        if (bus.clear_req)       state_n = S_CLR;
        else if (bus.rule_valid) state_n = S_MIX1;
      end
      S_MIX1: state_n = S_MIX2;
      S_MIX2: state_n = S_WR0;
      S_WR0:  state_n = S_WR1;
      S_WR1:  state_n = S_WR2;
      S_WR2:  state_n = S_DONE;
      S_CLR:  if (wr_addr_q == LAST_ADDR) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    unique case (state_n)
      S_WR0: begin wr_en_n = 1'b1; wr_data_n = 1'b1; wr_addr_n = h1[ADDR_WIDTH-1:0]; end
      S_WR1: begin wr_en_n = 1'b1; wr_data_n = 1'b1; wr_addr_n = idx2; end
      S_WR2: begin wr_en_n = 1'b1; wr_data_n = 1'b1; wr_addr_n = idx3; end
      S_CLR: begin
        wr_en_n   = 1'b1;
        wr_addr_n = (state == S_CLR) ? ADDR_WIDTH'(wr_addr_q + 1'b1) : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state        <= S_IDLE;
      rule_ready_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 1'b0;
      wr_addr_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      rule_ready_q <= (state_n == S_IDLE);
      wr_en_q      <= wr_en_n;
      wr_data_q    <= wr_data_n;
      wr_addr_q    <= wr_addr_n;
      done_q       <= (state_n == S_DONE);
    end
  end

  // NOTE: hash datapath is not reset; it is always reloaded in IDLE before it is used.
  always_ff @(posedge clk) begin
    unique case (state)
      S_IDLE: begin
        a <= 32'hdeadbef8 + bus.ip_protocol[71:40];
        b <= 32'hdeadbef1 + {16'h0000, bus.src_port};
        c <= 32'hdeadbef8 + {16'h0000, bus.dst_port};
      end
      S_MIX1: a <= (a ^ c) - rotl(c, 4);
      S_MIX2: begin
        idx2 <= h2[ADDR_WIDTH-1:0];
        idx3 <= h3[ADDR_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign bus.rule_ready = rule_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.done       = done_q;

`ifdef LOADER_STATS_EN
  logic [15:0] insert_count_q;

  always_ff @(posedge clk) begin
    if (rst)
      insert_count_q <= '0;
    else if (state == S_WR2 && insert_count_q != 16'hFFFF)
      insert_count_q <= insert_count_q + 16'd1;
    else if (state == S_CLR && state_n == S_DONE)
      insert_count_q <= '0;
  end

  assign bus.insert_count = insert_count_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.ip_protocol[39:0], h1[31:ADDR_WIDTH],
                         h2[31:ADDR_WIDTH], h3[31:ADDR_WIDTH]};

endmodule

// File: tb/tb_bloom_rule_loader.sv
// Self-checking bench for bloom_rule_loader: cycle-level expectation queue built from the hash rules.
// Define LOADER_STATS_EN to also check insert_count.
module tb_bloom_rule_loader;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bloom_rule_loader_if #(.ADDR_WIDTH(AW)) bus ();
  bloom_rule_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          ready;
    logic          en;
    logic          data;
    logic          done;
    logic [1:0]    op;     // 1: count an insert, 2: zero the count
    logic [AW-1:0] addr;
  } exp_t;

  function automatic exp_t mk(input logic ready, en, data, done, input logic [1:0] op,
                              input int addr);
    exp_t e;
    e.ready = ready; e.en = en; e.data = data; e.done = done; e.op = op;
    e.addr  = AW'(addr);
    return e;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic void spec_hash(input logic [71:0] ip, input logic [15:0] s, input logic [15:0] d,
                                    output logic [31:0] am, output logic [31:0] h1,
                                    output logic [31:0] h2, output logic [31:0] h3);
    logic [31:0] a, b, c;
    a  = 32'hdeadbef8 + ip[71:40];
    b  = 32'hdeadbef1 + {16'h0, s};
    c  = 32'hdeadbef8 + {16'h0, d};
    am = (a ^ c) - rotl(c, 4);
    h1 = (b ^ am) - rotl(am, 14);
    h2 = (b ^ am) - rotl(am, 22);
    h3 = (b ^ am) - rotl(am, 16);
  endfunction

  exp_t        q[$];
  exp_t        cur;
  logic [15:0] model_count;
  bit          check_en = 1'b0;

  always @(posedge clk) begin
    logic [31:0] am, h1, h2, h3;
    if (rst) begin
      q.delete();
      cur         = mk(1, 0, 0, 0, 0, 0);
      model_count = '0;
    end else begin
      if (q.size() == 0 && cur.ready && (bus.clear_req || bus.rule_valid)) begin
        if (bus.clear_req) begin
          for (int k = 0; k < DEPTH; k++) q.push_back(mk(0, 1, 0, 0, 0, k));
          q.push_back(mk(0, 0, 0, 1, 2, 0));
        end else begin
          spec_hash(bus.ip_protocol, bus.src_port, bus.dst_port, am, h1, h2, h3);
          q.push_back(mk(0, 0, 0, 0, 0, 0));
          q.push_back(mk(0, 0, 0, 0, 0, 0));
          q.push_back(mk(0, 1, 1, 0, 0, int'(h1[AW-1:0])));
          q.push_back(mk(0, 1, 1, 0, 0, int'(h2[AW-1:0])));
          q.push_back(mk(0, 1, 1, 0, 0, int'(h3[AW-1:0])));
          q.push_back(mk(0, 0, 0, 1, 1, 0));
        end
      end
      if (q.size() > 0) cur = q.pop_front();
      else              cur = mk(1, 0, 0, 0, 0, 0);
      if (cur.op == 2'd1 && model_count != 16'hFFFF) model_count = model_count + 16'd1;
      else if (cur.op == 2'd2)                       model_count = '0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("rule_ready", 32'(bus.rule_ready), 32'(cur.ready));
      check("wr_en",      32'(bus.wr_en),      32'(cur.en));
      check("done",       32'(bus.done),       32'(cur.done));
      if (cur.en) begin
        check("wr_addr", 32'(bus.wr_addr), 32'(cur.addr));
        check("wr_data", 32'(bus.wr_data), 32'(cur.data));
      end
`ifdef LOADER_STATS_EN
      check("insert_count", 32'(bus.insert_count), 32'(model_count));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [AW-1:0] wq[$];
  bit            ready_seen;

  task automatic wait_done(input string name, input int exp_lat);
    int n;
    bit seen = 1'b0;
    wq.delete();
    ready_seen = 1'b0;
    for (n = 1; n <= 40; n++) begin
      if (bus.wr_en) wq.push_back(bus.wr_addr);
      if (bus.rule_ready) ready_seen = 1'b1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    if (seen) check({name, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic send(input bit clr, input logic [71:0] ip, input logic [15:0] s,
                      input logic [15:0] d, input string name, input int exp_lat);
    int w = 0;
    while (!bus.rule_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus.ip_protocol = ip;
    bus.src_port    = s;
    bus.dst_port    = d;
    bus.clear_req   = clr;
    bus.rule_valid  = !clr;
    @(negedge clk);
    bus.rule_valid  = 1'b0;
    bus.clear_req   = 1'b0;
    wait_done(name, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] am, h1, h2, h3;
    int gap;

    rst             = 1'b1;
    bus.rule_valid  = 1'b0;
    bus.clear_req   = 1'b0;
    bus.ip_protocol = '0;
    bus.src_port    = '0;
    bus.dst_port    = '0;

    // Model pinned against hand-computed hash values.
    spec_hash(72'h0, 16'h0, 16'h0, am, h1, h2, h3);
    check("model mix a", am, 32'h15241073);
    check("model h1",    h1, 32'hc76ce939);
    check("model h2",    h2, 32'haec4657e);
    check("model h3",    h3, 32'hbb16995e);

    // 1: reset
    repeat (2) @(negedge clk);
    check("reset rule_ready", 32'(bus.rule_ready), 32'd1);
    check("reset wr_en",      32'(bus.wr_en),      32'd0);
    check("reset wr_addr",    32'(bus.wr_addr),    32'd0);
    check("reset wr_data",    32'(bus.wr_data),    32'd0);
    check("reset done",       32'(bus.done),       32'd0);
`ifdef LOADER_STATS_EN
    check("reset insert_count", 32'(bus.insert_count), 32'd0);
`endif
    check_en = 1'b1;
    rst      = 1'b0;
    @(negedge clk);

    // 2: all-zero rule -> writes 1,6,6
    send(1'b0, 72'h0, 16'h0, 16'h0, "insert zero", 6);
    check("zero write count", 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      check("zero addr0", 32'(wq[0]), 32'd1);
      check("zero addr1", 32'(wq[1]), 32'd6);
      check("zero addr2", 32'(wq[2]), 32'd6);
    end
    @(negedge clk);

    // Distinct patterns; low 40 bits of ip_protocol must not matter.
    send(1'b0, 72'h12_3456_789a_bcde_f011, 16'h0050, 16'h01bb, "insert p1", 6);
    @(negedge clk);
    send(1'b0, 72'h12_3456_7800_0000_0000, 16'h0050, 16'h01bb, "insert p1 low0", 6);
    @(negedge clk);
    send(1'b0, 72'hff_ffff_ffff_ffff_ffff, 16'hffff, 16'hffff, "insert ones", 6);
    @(negedge clk);
    send(1'b0, 72'hc0_a801_0106_0000_0000, 16'h1f90, 16'h0016, "insert p2", 6);
    @(negedge clk);

    // 3: clear
    send(1'b1, 72'h0, 16'h0, 16'h0, "clear", DEPTH + 1);
    check("clear write count", 32'(wq.size()), 32'(DEPTH));
    for (int k = 0; k < DEPTH && k < wq.size(); k++)
      check("clear addr", 32'(wq[k]), 32'(k));
    @(negedge clk);

    // 4: clear and rule together; rule held and taken after the clear finishes
    bus.ip_protocol = 72'hab_cdef_0123_0000_0000;
    bus.src_port    = 16'h1234;
    bus.dst_port    = 16'h5678;
    bus.clear_req   = 1'b1;
    bus.rule_valid  = 1'b1;
    @(negedge clk);
    bus.clear_req   = 1'b0;
    wait_done("both clear", DEPTH + 1);
    check("both ready stayed low", 32'(ready_seen), 32'd0);
    check("both wrote clear", 32'(wq.size()), 32'(DEPTH));
    @(negedge clk);
    check("both ready after done", 32'(bus.rule_ready), 32'd1);
    @(negedge clk);
    bus.rule_valid = 1'b0;
    wait_done("both held rule", 6);
    @(negedge clk);

    // 5: reset during WR1
    bus.ip_protocol = 72'h0a_0000_0100_0000_0000;
    bus.src_port    = 16'h0101;
    bus.dst_port    = 16'h0202;
    bus.rule_valid  = 1'b1;
    @(negedge clk);
    bus.rule_valid  = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset wr_en in WR1", 32'(bus.wr_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort wr_en",      32'(bus.wr_en),      32'd0);
    check("abort rule_ready", 32'(bus.rule_ready), 32'd1);
    check("abort done",       32'(bus.done),       32'd0);
    repeat (8) @(negedge clk);
    send(1'b0, 72'h0a_0000_0100_0000_0000, 16'h0101, 16'h0202, "post-reset insert", 6);
    @(negedge clk);

    // 6: zero the count, then 3 back-to-back inserts
    send(1'b1, 72'h0, 16'h0, 16'h0, "clear before b2b", DEPTH + 1);
    @(negedge clk);
    bus.ip_protocol = 72'h01_0203_0400_0000_0000;
    bus.src_port    = 16'h0001;
    bus.dst_port    = 16'h0002;
    bus.rule_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!bus.done && gap < 40);
      check("b2b done gap", 32'(gap), (i == 0) ? 32'd6 : 32'd7);
      bus.ip_protocol = bus.ip_protocol + 72'h01_0000_0000_0000_0000;
      bus.src_port    = bus.src_port + 16'd3;
      if (i == 2) bus.rule_valid = 1'b0;
    end
`ifdef LOADER_STATS_EN
    check("b2b insert_count", 32'(bus.insert_count), 32'd3);
`endif
    repeat (4) @(negedge clk);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
